conv_layer_scheduler: RTL and testbench

CONV_LAYER_SCHEDULER -- requirements
Module: conv_layer_scheduler

---
 rtl/conv_sched_pkg.sv | 38 +++
 rtl/conv_layer_scheduler_if.sv | 34 +++
 rtl/conv_desc_table.sv | 42 ++++
 rtl/conv_layer_scheduler.sv | 128 ++++++++++++
 tb/tb_conv_layer_scheduler.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_sched_pkg.sv
// Shared types for the convolution layer scheduler: the packed layer
// descriptor, its width, the sequencer state encoding and a small helper.
package conv_sched_pkg;

  typedef struct packed {
    logic [3:0]  stride;
    logic [3:0]  kernel;
    logic [7:0]  window;
    logic [15:0] infeature_size;
    logic [15:0] in_ch;
    logic [15:0] out_ch;
    logic [15:0] outfeature_size;
    logic [7:0]  sliding;
    logic [15:0] outcol_times;
    logic [15:0] incol_times;
    logic [15:0] outrow_times;
    logic [15:0] outch_times;
    logic [15:0] weight_row;
    logic        switch_conv;
    logic        matrix2img;
  } layer_desc_t;

  localparam int LAYER_W = $bits(layer_desc_t);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_BUSY,
    ST_DONE
  } sched_state_t;

  // A run request is only meaningful for 1..depth layers.
  function automatic logic count_ok(input logic [15:0] n, input int depth);
    return (n != 16'd0) && (int'(n) <= depth);
  endfunction

endpackage

// File: rtl/conv_layer_scheduler_if.sv
// Host/Conv-side signal bundle of the layer scheduler. The master modport
// is the host and Conv engine side; the slave modport is the scheduler.
interface conv_layer_scheduler_if #(
  parameter int DEPTH = 8
);
  import conv_sched_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic              cfg_we;
  logic [AW-1:0]     cfg_addr;
  layer_desc_t       cfg_wdata;
  logic              run;
  logic [AW:0]       num_layers;
  logic              abort;
  logic              conv_last;
  logic              conv_start;
  layer_desc_t       layer_cfg;
  logic              busy;
  logic [AW-1:0]     layer_idx;
  logic              all_done;
  logic              error;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, run, num_layers, abort, conv_last,
    input  conv_start, layer_cfg, busy, layer_idx, all_done, error
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, run, num_layers, abort, conv_last,
    output conv_start, layer_cfg, busy, layer_idx, all_done, error
  );

endinterface

// File: rtl/conv_desc_table.sv
// Descriptor table: DEPTH entries of one layer descriptor each, one write
// port and one synchronous read port. The storage itself is never reset;
// only the read register is, so the active descriptor starts at zero.
module conv_desc_table
  import conv_sched_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  layer_desc_t   i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output layer_desc_t   o_rdata
);

  logic [LAYER_W-1:0] r_mem [DEPTH];
  layer_desc_t        r_rdata;

  // Host writes land in the table at any time.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read register only updates when asked, so later table writes do not
  // disturb the descriptor currently being executed.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= layer_desc_t'(r_mem[i_raddr]);
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/conv_layer_scheduler.sv
// Convolution layer scheduler: walks descriptor entries 0..num_layers-1,
// presents each descriptor to the Conv engine, pulses conv_start, waits for
// conv_last (guarded by a watchdog) and signals all_done after the last one.
module conv_layer_scheduler
  import conv_sched_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 2 ** 24
) (
  input logic                    clk,
  input logic                    reset,
  conv_layer_scheduler_if.slave  bus
);

  localparam int AW   = $clog2(DEPTH);
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

  sched_state_t    r_state;
  sched_state_t    w_state_nxt;
  logic [AW-1:0]   r_idx;
  logic [AW-1:0]   w_idx_nxt;
  logic [AW:0]     r_num;
  logic [AW:0]     w_num_nxt;
  logic [WD_W-1:0] r_wd;
  logic [WD_W-1:0] w_wd_nxt;
  logic            r_err;
  logic            w_err_nxt;
  logic            w_run_ok;
  logic            w_last_layer;
  logic            w_load;
  layer_desc_t     w_layer_cfg;

  assign w_run_ok     = bus.run && count_ok(16'(bus.num_layers), DEPTH);
  assign w_last_layer = ({1'b0, r_idx} == (r_num - (AW + 1)'(1)));
  assign w_load       = (r_state == ST_LOAD) && !bus.abort;

  conv_desc_table #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_table (
    .clk     (clk),
    .reset   (reset),
    .i_we    (bus.cfg_we),
    .i_waddr (bus.cfg_addr),
    .i_wdata (bus.cfg_wdata),
    .i_re    (w_load),
    .i_raddr (r_idx),
    .o_rdata (w_layer_cfg)
  );

  // Sequencer state, layer index, captured layer count, watchdog, error.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_num   <= '0;
      r_wd    <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_num   <= w_num_nxt;
      r_wd    <= w_wd_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Next-state logic; abort wins over every other transition.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_num_nxt   = r_num;
    w_wd_nxt    = r_wd;
    w_err_nxt   = r_err;
    if (bus.abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_run_ok) begin
            w_state_nxt = ST_LOAD;
            w_idx_nxt   = '0;
            w_num_nxt   = bus.num_layers;
            w_err_nxt   = 1'b0;
          end
        end
        ST_LOAD: begin
          w_state_nxt = ST_START;
        end
        ST_START: begin
          w_state_nxt = ST_BUSY;
          w_wd_nxt    = '0;
        end
        ST_BUSY: begin
          // Completion on the expiry cycle still counts as completion.
          if (bus.conv_last) begin
            if (w_last_layer) begin
              w_state_nxt = ST_DONE;
            end else begin
              w_state_nxt = ST_LOAD;
              w_idx_nxt   = r_idx + AW'(1);
            end
          end else if (r_wd == WD_MAX) begin
            w_state_nxt = ST_IDLE;
            w_err_nxt   = 1'b1;
          end else begin
            w_wd_nxt = r_wd + WD_W'(1);
          end
        end
        ST_DONE: begin
          w_state_nxt = ST_IDLE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign bus.conv_start = (r_state == ST_START) && !bus.abort;
  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.all_done   = (r_state == ST_DONE);
  assign bus.layer_idx  = r_idx;
  assign bus.error      = r_err;
  assign bus.layer_cfg  = w_layer_cfg;

endmodule

// File: tb/tb_conv_layer_scheduler.sv
// Directed bench for conv_layer_scheduler: one instance with the default
// watchdog for sequencing tests and one with TIMEOUT=16 for expiry tests.
module tb_conv_layer_scheduler;
  import conv_sched_pkg::*;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  conv_layer_scheduler_if #(.DEPTH(DEPTH)) ia ();
  conv_layer_scheduler_if #(.DEPTH(DEPTH)) it ();

  conv_layer_scheduler #(.DEPTH(DEPTH)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ia)
  );

  conv_layer_scheduler #(.DEPTH(DEPTH), .TIMEOUT(16)) dut_t (
    .clk   (clk),
    .reset (reset),
    .bus   (it)
  );

  int n_cmp = 0;
  int n_err = 0;
  int a_starts = 0;
  int a_dones  = 0;
  int t_starts = 0;
  int t_dones  = 0;

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (ia.conv_start) a_starts = a_starts + 1;
    if (ia.all_done)   a_dones  = a_dones + 1;
    if (it.conv_start) t_starts = t_starts + 1;
    if (it.all_done)   t_dones  = t_dones + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic layer_desc_t mk(input int n, input int st, input int kn,
                                     input int isz, input int ich, input int och,
                                     input int osz);
    layer_desc_t d;
    d.stride          = 4'(st);
    d.kernel          = 4'(kn);
    d.window          = 8'(kn * kn);
    d.infeature_size  = 16'(isz);
    d.in_ch           = 16'(ich);
    d.out_ch          = 16'(och);
    d.outfeature_size = 16'(osz);
    d.sliding         = 8'(n + 1);
    d.outcol_times    = 16'(osz + n);
    d.incol_times     = 16'(isz + n);
    d.outrow_times    = 16'(osz + 2 * n);
    d.outch_times     = 16'(och / 8);
    d.weight_row      = 16'(ich * kn);
    d.switch_conv     = n[0];
    d.matrix2img      = ~n[0];
    return d;
  endfunction

  task automatic wr_a(input logic [2:0] ad, input layer_desc_t d);
    ia.cfg_we = 1'b1; ia.cfg_addr = ad; ia.cfg_wdata = d;
    tick();
    ia.cfg_we = 1'b0;
  endtask

  task automatic wr_t(input logic [2:0] ad, input layer_desc_t d);
    it.cfg_we = 1'b1; it.cfg_addr = ad; it.cfg_wdata = d;
    tick();
    it.cfg_we = 1'b0;
  endtask

  task automatic run_a(input logic [3:0] n);
    ia.run = 1'b1; ia.num_layers = n;
    tick();
    ia.run = 1'b0;
  endtask

  task automatic run_t(input logic [3:0] n);
    it.run = 1'b1; it.num_layers = n;
    tick();
    it.run = 1'b0;
  endtask

  task automatic last_a();
    ia.conv_last = 1'b1;
    tick();
    ia.conv_last = 1'b0;
  endtask

  layer_desc_t e [3];
  layer_desc_t e1b;
  int s0, d0;

  initial begin
    e[0] = mk(0, 2, 3, 322, 32, 64, 160);
    e[1] = mk(1, 1, 3, 160, 64, 128, 158);
    e[2] = mk(2, 2, 5, 158, 128, 256, 77);
    e1b  = mk(7, 3, 7, 999, 11, 22, 33);

    ia.cfg_we = 0; ia.cfg_addr = '0; ia.cfg_wdata = '0; ia.run = 0;
    ia.num_layers = '0; ia.abort = 0; ia.conv_last = 0;
    it.cfg_we = 0; it.cfg_addr = '0; it.cfg_wdata = '0; it.run = 0;
    it.num_layers = '0; it.abort = 0; it.conv_last = 0;
    reset = 1'b1;
    ticks(3);
    reset = 1'b0;

    // Reset state
    chk("rst_busy", 256'(ia.busy), 256'(0));
    chk("rst_start", 256'(ia.conv_start), 256'(0));
    chk("rst_done", 256'(ia.all_done), 256'(0));
    chk("rst_error", 256'(ia.error), 256'(0));
    chk("rst_idx", 256'(ia.layer_idx), 256'(0));
    chk("rst_cfg", 256'(ia.layer_cfg), 256'(0));

    for (int i = 0; i < 3; i++) wr_a(3'(i), e[i]);

    // Single layer, conv_last 100 cycles after start
    s0 = a_starts; d0 = a_dones;
    run_a(4'd1);
    chk("t1_busy_load", 256'(ia.busy), 256'(1));
    chk("t1_nostart_load", 256'(ia.conv_start), 256'(0));
    tick();
    chk("t1_start", 256'(ia.conv_start), 256'(1));
    chk("t1_cfg", 256'(ia.layer_cfg), 256'(e[0]));
    chk("t1_idx", 256'(ia.layer_idx), 256'(0));
    tick();
    chk("t1_start_off", 256'(ia.conv_start), 256'(0));
    ticks(99);
    last_a();
    chk("t1_all_done", 256'(ia.all_done), 256'(1));
    tick();
    chk("t1_done_off", 256'(ia.all_done), 256'(0));
    chk("t1_idle", 256'(ia.busy), 256'(0));
    chk("t1_nstarts", 256'(a_starts - s0), 256'(1));
    chk("t1_ndones", 256'(a_dones - d0), 256'(1));

    // Three layers, 50 cycles each; entry 1 rewritten while it executes
    s0 = a_starts; d0 = a_dones;
    run_a(4'd3);
    for (int l = 0; l < 3; l++) begin
      tick();
      chk("t2_start", 256'(ia.conv_start), 256'(1));
      chk("t2_idx", 256'(ia.layer_idx), 256'(l));
      chk("t2_cfg", 256'(ia.layer_cfg), 256'(e[l]));
      tick();
      if (l == 1) begin
        wr_a(3'd1, e1b);
        ticks(48);
        chk("t2_cfg_hold", 256'(ia.layer_cfg), 256'(e[1]));
      end else begin
        ticks(49);
      end
      last_a();
      if (l < 2) begin
        chk("t2_load_nostart", 256'(ia.conv_start), 256'(0));
        chk("t2_load_nodone", 256'(ia.all_done), 256'(0));
      end
    end
    chk("t2_all_done", 256'(ia.all_done), 256'(1));
    tick();
    chk("t2_idle", 256'(ia.busy), 256'(0));
    chk("t2_nstarts", 256'(a_starts - s0), 256'(3));
    chk("t2_ndones", 256'(a_dones - d0), 256'(1));
    wr_a(3'd1, e[1]);

    // Abort during layer 1 of 3, plus ignored run requests
    s0 = a_starts; d0 = a_dones;
    run_a(4'd3);
    ticks(2);
    ticks(9);
    last_a();
    tick();
    chk("t3_idx1", 256'(ia.layer_idx), 256'(1));
    tick();
    ia.run = 1'b1; ia.num_layers = 4'd1;
    tick();
    ia.run = 1'b0;
    chk("t3_run_busy_idx", 256'(ia.layer_idx), 256'(1));
    chk("t3_run_busy_nostart", 256'(ia.conv_start), 256'(0));
    ia.abort = 1'b1;
    tick();
    ia.abort = 1'b0;
    chk("t3_abort_idle", 256'(ia.busy), 256'(0));
    chk("t3_abort_err", 256'(ia.error), 256'(0));
    ticks(5);
    chk("t3_nstarts", 256'(a_starts - s0), 256'(2));
    chk("t3_ndones", 256'(a_dones - d0), 256'(0));
    run_a(4'd0);
    chk("t3_zero_idle", 256'(ia.busy), 256'(0));
    tick();
    chk("t3_zero_nostart", 256'(ia.conv_start), 256'(0));
    run_a(4'd9);
    chk("t3_big_idle", 256'(ia.busy), 256'(0));
    tick();
    chk("t3_big_nostart", 256'(a_starts - s0), 256'(2));

    // Reset during BUSY, then a fresh two-layer run from the kept table
    d0 = a_dones;
    run_a(4'd3);
    ticks(5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t4_busy", 256'(ia.busy), 256'(0));
    chk("t4_idx", 256'(ia.layer_idx), 256'(0));
    chk("t4_cfg", 256'(ia.layer_cfg), 256'(0));
    chk("t4_start", 256'(ia.conv_start), 256'(0));
    run_a(4'd2);
    tick();
    chk("t4_l0_start", 256'(ia.conv_start), 256'(1));
    chk("t4_l0_cfg", 256'(ia.layer_cfg), 256'(e[0]));
    ticks(4);
    last_a();
    tick();
    chk("t4_l1_start", 256'(ia.conv_start), 256'(1));
    chk("t4_l1_idx", 256'(ia.layer_idx), 256'(1));
    chk("t4_l1_cfg", 256'(ia.layer_cfg), 256'(e[1]));
    ticks(3);
    last_a();
    chk("t4_all_done", 256'(ia.all_done), 256'(1));
    tick();
    chk("t4_ndones", 256'(a_dones - d0), 256'(1));

    // Watchdog expiry with TIMEOUT=16
    wr_t(3'd0, e[2]);
    d0 = t_dones;
    run_t(4'd1);
    tick();
    chk("t5_start", 256'(it.conv_start), 256'(1));
    tick();
    ticks(15);
    chk("t5_busy_wd15", 256'(it.busy), 256'(1));
    chk("t5_noerr_wd15", 256'(it.error), 256'(0));
    tick();
    chk("t5_err", 256'(it.error), 256'(1));
    chk("t5_idle", 256'(it.busy), 256'(0));
    chk("t5_nodone", 256'(t_dones - d0), 256'(0));
    run_t(4'd1);
    chk("t5_err_cleared", 256'(it.error), 256'(0));
    tick();
    tick();
    ticks(15);
    it.conv_last = 1'b1;
    tick();
    it.conv_last = 1'b0;
    chk("t5_edge_done", 256'(it.all_done), 256'(1));
    chk("t5_edge_noerr", 256'(it.error), 256'(0));
    tick();
    chk("t5_edge_idle", 256'(it.busy), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
